// File: rtl/ir_nec_command_decoder.sv
// NEC IR decoder: times marks/spaces in microseconds, assembles and validates 32-bit frames, and holds a 3-bit drive command.
// cmd_valid is registered 4 clk after the stop-mark falling edge; there is no backpressure, and every pulse output is a one-cycle strobe.
module ir_nec_command_decoder #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter logic [7:0]  ADDR        = 8'h00,
    parameter bit          CHECK_ADDR  = 1'b1,
    parameter logic [7:0]  KEY_LEFT    = 8'h08,
    parameter logic [7:0]  KEY_RIGHT   = 8'h5A,
    parameter logic [7:0]  KEY_FAST    = 8'h18,
    parameter logic [7:0]  KEY_SLOW    = 8'h52,
    parameter logic [7:0]  KEY_STOP    = 8'h1C,
    parameter int unsigned TIMEOUT_US  = 12000,
    parameter int unsigned HOLD_MS     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ir_in,
    output logic [2:0] state_control,
    output logic [7:0] key_code,
    output logic       cmd_valid,
    output logic       repeat_pulse,
    output logic       frame_error
);

    localparam int unsigned       CLKS_PER_US  = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned       PW           = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0]     PRESC_LAST   = PW'(CLKS_PER_US - 1);
    localparam logic [13:0]       DUR_MAX      = 14'h3FFF;
    localparam logic [13:0]       TIMEOUT_LAST = 14'(TIMEOUT_US - 1);
    localparam longint unsigned   HOLD_CLKS    = 64'(HOLD_MS) * 64'd1000 * 64'(CLKS_PER_US);
    localparam longint unsigned   HOLD_LAST    = (HOLD_CLKS == 0) ? 64'd0 : HOLD_CLKS - 64'd1;
    localparam int unsigned       HW           = $clog2(HOLD_LAST + 2);
    localparam logic [HW-1:0]     HOLD_LAST_W  = HW'(HOLD_LAST);

    localparam logic [13:0] LM_MIN  = 14'd8000, LM_MAX  = 14'd10000;
    localparam logic [13:0] LSD_MIN = 14'd4000, LSD_MAX = 14'd5000;
    localparam logic [13:0] LSR_MIN = 14'd1800, LSR_MAX = 14'd2700;
    localparam logic [13:0] BM_MIN  = 14'd300,  BM_MAX  = 14'd800;
    localparam logic [13:0] B0_MIN  = 14'd300,  B0_MAX  = 14'd800;
    localparam logic [13:0] B1_MIN  = 14'd1300, B1_MAX  = 14'd2000;

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_RPT_MARK, S_CHECK
    } state_t;

    logic          r_sync1, r_sync2, r_ir_prev;
    logic          w_fall, w_rise, w_edge, w_tick;
    logic [PW-1:0] r_presc;
    logic [13:0]   r_dur;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_shift, w_shift_nxt;
    logic [5:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic          r_have_frame, w_have_nxt;
    logic [7:0]    r_key, w_key_nxt;
    logic [2:0]    r_sc, w_sc_nxt;
    logic          r_cmd_valid, r_repeat, r_ferr;
    logic          w_cv_nxt, w_rp_nxt, w_fe_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic          r_hold_act, w_hold_expire;

    logic w_lead_ok, w_hdr_data, w_hdr_rpt, w_mark_ok, w_sp0, w_sp1;
    logic w_timeout, w_frame_ok;
    logic [7:0] w_cmd, w_ncmd, w_addr, w_naddr;

    // Synchronizer resets to the idle-high level so release of reset creates no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_ir_prev <= 1'b1;
        end else begin
            r_sync1   <= ir_in;
            r_sync2   <= r_sync1;
            r_ir_prev <= r_sync2;
        end
    end

    assign w_fall = r_ir_prev & ~r_sync2;
    assign w_rise = ~r_ir_prev & r_sync2;
    assign w_edge = w_fall | w_rise;
    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_dur   <= '0;
        end else if (w_edge) begin
            r_presc <= '0;
            r_dur   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            if (r_dur != DUR_MAX) r_dur <= r_dur + 14'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign w_lead_ok  = (r_dur >= LM_MIN)  && (r_dur <= LM_MAX);
    assign w_hdr_data = (r_dur >= LSD_MIN) && (r_dur <= LSD_MAX);
    assign w_hdr_rpt  = (r_dur >= LSR_MIN) && (r_dur <= LSR_MAX);
    assign w_mark_ok  = (r_dur >= BM_MIN)  && (r_dur <= BM_MAX);
    assign w_sp0      = (r_dur >= B0_MIN)  && (r_dur <= B0_MAX);
    assign w_sp1      = (r_dur >= B1_MIN)  && (r_dur <= B1_MAX);
    // Fires on the cycle the duration counter steps onto TIMEOUT_US.
    assign w_timeout  = w_tick && !w_edge && (r_dur == TIMEOUT_LAST);

    assign w_addr  = r_shift[7:0];
    assign w_naddr = r_shift[15:8];
    assign w_cmd   = r_shift[23:16];
    assign w_ncmd  = r_shift[31:24];
    assign w_frame_ok = (w_cmd == ~w_ncmd) &&
                        (!CHECK_ADDR || ((w_addr == ADDR) && (w_naddr == ~w_addr)));

    function automatic logic [2:0] map_cmd(input logic [7:0] c, input logic [2:0] cur);
        if (c == KEY_LEFT)       return 3'b001;
        else if (c == KEY_RIGHT) return 3'b010;
        else if (c == KEY_FAST)  return 3'b011;
        else if (c == KEY_SLOW)  return 3'b100;
        else if (c == KEY_STOP)  return 3'b000;
        else                     return cur;
    endfunction

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_have_nxt    = r_have_frame;
        w_key_nxt     = r_key;
        w_sc_nxt      = r_sc;
        w_cv_nxt      = 1'b0;
        w_rp_nxt      = 1'b0;
        w_fe_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_nxt = S_LEAD_MARK;
            end
            S_LEAD_MARK: begin
                // A bad leader mark is treated as line noise and dropped silently.
                if (w_rise) w_state_nxt = w_lead_ok ? S_LEAD_SPACE : S_IDLE;
            end
            S_LEAD_SPACE: begin
                if (w_fall) begin
                    if (w_hdr_data) begin
                        w_state_nxt   = S_BIT_MARK;
                        w_bit_cnt_nxt = 6'd0;
                    end else if (w_hdr_rpt) begin
                        w_state_nxt = S_RPT_MARK;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_fe_nxt    = 1'b1;
                    end
                end
            end
            S_BIT_MARK: begin
                if (w_rise) begin
                    if (w_mark_ok) begin
                        w_state_nxt = S_BIT_SPACE;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_fe_nxt    = 1'b1;
                    end
                end
            end
            S_BIT_SPACE: begin
                if (w_fall) begin
                    if (w_sp0 || w_sp1) begin
                        w_shift_nxt   = {w_sp1, r_shift[31:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                        w_state_nxt   = (r_bit_cnt == 6'd31) ? S_CHECK : S_BIT_MARK;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_fe_nxt    = 1'b1;
                    end
                end
            end
            S_RPT_MARK: begin
                if (w_rise) begin
                    w_state_nxt = S_IDLE;
                    if (w_mark_ok) w_rp_nxt = r_have_frame;
                    else           w_fe_nxt = 1'b1;
                end
            end
            S_CHECK: begin
                w_state_nxt = S_IDLE;
                if (w_frame_ok) begin
                    w_cv_nxt   = 1'b1;
                    w_have_nxt = 1'b1;
                    w_key_nxt  = w_cmd;
                    w_sc_nxt   = map_cmd(w_cmd, r_sc);
                end else begin
                    w_fe_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if ((r_state != S_IDLE) && (r_state != S_CHECK) && w_timeout) begin
            w_state_nxt = S_IDLE;
            w_fe_nxt    = 1'b1;
        end
    end

    assign w_hold_expire = (HOLD_MS != 0) && r_hold_act && (r_hold_cnt == HOLD_LAST_W) &&
                           !w_cv_nxt && !w_rp_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_have_frame <= 1'b0;
            r_key        <= '0;
            r_sc         <= '0;
            r_cmd_valid  <= 1'b0;
            r_repeat     <= 1'b0;
            r_ferr       <= 1'b0;
            r_hold_cnt   <= '0;
            r_hold_act   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_have_frame <= w_have_nxt;
            r_key        <= w_key_nxt;
            r_sc         <= w_hold_expire ? 3'b000 : w_sc_nxt;
            r_cmd_valid  <= w_cv_nxt;
            r_repeat     <= w_rp_nxt;
            r_ferr       <= w_fe_nxt;
            // Hold window restarts on every accepted frame or repeat.
            if (w_cv_nxt || w_rp_nxt) begin
                r_hold_cnt <= '0;
                r_hold_act <= (HOLD_MS != 0);
            end else if (r_hold_act) begin
                if (r_hold_cnt == HOLD_LAST_W) r_hold_act <= 1'b0;
                else                           r_hold_cnt <= r_hold_cnt + HW'(1);
            end
        end
    end

    assign state_control = r_sc;
    assign key_code      = r_key;
    assign cmd_valid     = r_cmd_valid;
    assign repeat_pulse  = r_repeat;
    assign frame_error   = r_ferr;

endmodule
